// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//
// Self-timed control sequencer for the TTL16 CPU. Owns the instruction step
// state and decodes the datapath control strobes for fetch, LDVAL, LDMEM, STR,
// MOV, ALU/compare and conditional branches. It also provides an interrupt-enable
// flag and a two-cycle interrupt entry sequence.
//
// Optional feature macro: MICROCODE_WAIT_EN
//   defined   : MemReady gates bus steps, a wait counter runs, and BusErr pulses
//               once the counter reaches WAIT_LIMIT.
//   undefined : MemReady is ignored, there is no wait counter, BusErr is 0.
//
// Parameters
//   WAIT_LIMIT : stalled cycles before a bus error (0 = never time out)
//   LINK_REG   : register that receives the return PC on interrupt entry
//   IVEC_REG   : register that holds the interrupt vector
//
// Ports
//   CLK, RST                        clock, async active-high reset
//   Instr[15:0], Flags[4:0]         instruction register, ALU flags
//   MemReady                        bus access completes this cycle
//   IntReq                          level interrupt request (sampled at boundary)
//   Step[2:0]                       current state code (debug)
//   PCToA, PCW, PCWriteFromD, PCToD PC controls
//   DToInstr, ALUToD, shiftInstrToD data bus sources
//   rsel0RegFile, rsel1RegFile,
//   wselRegFile, wRegFile           register file selects / write strobe
//   rsel0ToA, rsel1ToD              register file onto address / data bus
//   wFlags, wOut                    flag write, memory write strobes
//   IntEnabled, IntAck, BusErr      interrupt enable, acknowledge, bus timeout
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH_A  | drive PC onto the address bus
// FETCH_D  | latch instruction from memory, increment PC (bus step)
// EXEC_S   | first execute step; branches finish here
// EXEC_W   | second execute step; writes (LDMEM/STR are bus steps)
// INT_SAVE | write return PC into LINK_REG, acknowledge the interrupt
// INT_JUMP | load PC from IVEC_REG, clear the interrupt enable

module microcode_sequencer #(
   parameter int         WAIT_LIMIT = 16,
   parameter logic [3:0] LINK_REG   = 4'hE,
   parameter logic [3:0] IVEC_REG   = 4'hF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] Instr,
   input  logic [4:0]  Flags,
   input  logic        MemReady,
   input  logic        IntReq,
   output logic [2:0]  Step,
   output logic        PCToA,
   output logic        PCW,
   output logic        PCWriteFromD,
   output logic        PCToD,
   output logic        DToInstr,
   output logic        ALUToD,
   output logic        shiftInstrToD,
   output logic [3:0]  rsel0RegFile,
   output logic [3:0]  rsel1RegFile,
   output logic [3:0]  wselRegFile,
   output logic        wRegFile,
   output logic        rsel0ToA,
   output logic        rsel1ToD,
   output logic        wFlags,
   output logic        wOut,
   output logic        IntEnabled,
   output logic        IntAck,
   output logic        BusErr
);

   typedef enum logic [2:0] {
      FETCH_A  = 3'd0,
      FETCH_D  = 3'd1,
      EXEC_S   = 3'd2,
      EXEC_W   = 3'd3,
      INT_SAVE = 3'd4,
      INT_JUMP = 3'd5
   } stateT;

   stateT state;

   logic isLdval, isMem, isAlu, isBranch;
   logic isLdmem, isStr;
   logic inExecW;
   logic taken;
   logic ready;     // bus step may complete this cycle (strobe gate)
   logic stall;     // bus step holds its state this cycle
   logic timeout;   // wait limit reached: abandon instruction

   assign isLdval  = ~Instr[15];
   assign isMem    = Instr[15] & (Instr[14:10] == 5'd0);
   assign isAlu    = Instr[15] & Instr[14];
   assign isBranch = Instr[15] & ~Instr[14] & (Instr[13:10] != 4'd0);
   assign isLdmem  = isMem & ~Instr[8];
   assign isStr    = isMem & (Instr[9:8] == 2'b01);
   assign inExecW  = (state == EXEC_W);

   // Instr[9] is the always-true condition; Instr[10] inverts the flag tests.
   assign taken = |(Instr[9:4] & {1'b1, Flags ^ {5{Instr[10]}}});

`ifdef MICROCODE_WAIT_EN
   localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

   logic [CW-1:0] waitCnt;
   logic          busStep;

   assign busStep = (state == FETCH_D) | (inExecW & (isLdmem | isStr));
   assign timeout = (WAIT_LIMIT != 0) && busStep && (waitCnt == CW'(WAIT_LIMIT));
   assign ready   = MemReady & ~timeout;
   assign stall   = busStep & ~MemReady & ~timeout;
`else
   logic unusedMemReady;

   assign unusedMemReady = MemReady;
   assign timeout        = 1'b0;
   assign ready          = 1'b1;
   assign stall          = 1'b0;
`endif

   assign Step   = state;
   assign BusErr = timeout;

   // Every strobe that a bus step can issue is gated by ready, so a timeout
   // cycle automatically suppresses them while selects stay put.
   always_comb begin
      PCToA         = 1'b0;
      PCW           = 1'b0;
      PCWriteFromD  = 1'b0;
      PCToD         = 1'b0;
      DToInstr      = 1'b0;
      ALUToD        = 1'b0;
      shiftInstrToD = 1'b0;
      rsel0RegFile  = 4'h0;
      rsel1RegFile  = 4'h0;
      wselRegFile   = 4'h0;
      wRegFile      = 1'b0;
      rsel0ToA      = 1'b0;
      rsel1ToD      = 1'b0;
      wFlags        = 1'b0;
      wOut          = 1'b0;
      IntAck        = 1'b0;
      case (state)
         FETCH_A: PCToA = 1'b1;
         FETCH_D: begin
            PCToA    = 1'b1;
            DToInstr = ready;
            PCW      = ready;
         end
         EXEC_S, EXEC_W: begin
            if (isLdval) begin
               shiftInstrToD = 1'b1;
               wselRegFile   = Instr[3:0];
               wRegFile      = inExecW;
            end else if (isMem) begin
               if (isLdmem) begin
                  rsel0RegFile = Instr[3:0];
                  rsel0ToA     = 1'b1;
                  wselRegFile  = Instr[7:4];
                  wRegFile     = inExecW & ready;
               end else if (isStr) begin
                  rsel0RegFile = Instr[3:0];
                  rsel0ToA     = 1'b1;
                  rsel1RegFile = Instr[7:4];
                  rsel1ToD     = 1'b1;
                  wOut         = inExecW & ready;
               end else begin
                  rsel1RegFile = Instr[3:0];
                  rsel1ToD     = 1'b1;
                  wselRegFile  = Instr[7:4];
                  wRegFile     = inExecW;
               end
            end else if (isAlu) begin
               rsel0RegFile = Instr[7:4];
               rsel1RegFile = Instr[3:0];
               wFlags       = inExecW;
               if (!Instr[13]) begin
                  ALUToD   = 1'b1;
                  wRegFile = inExecW;
               end
            end else if (!inExecW) begin
               rsel1RegFile = Instr[3:0];
               rsel1ToD     = 1'b1;
               PCW          = taken;
               PCWriteFromD = taken;
            end
         end
         INT_SAVE: begin
            PCToD       = 1'b1;
            wselRegFile = LINK_REG;
            wRegFile    = 1'b1;
            IntAck      = 1'b1;
         end
         INT_JUMP: begin
            rsel1RegFile = IVEC_REG;
            rsel1ToD     = 1'b1;
            PCW          = 1'b1;
            PCWriteFromD = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= FETCH_A;
         IntEnabled <= 1'b0;
`ifdef MICROCODE_WAIT_EN
         waitCnt    <= '0;
`endif
      end else begin
         case (state)
            FETCH_A: state <= FETCH_D;
            FETCH_D: begin
               if (timeout)
                  state <= FETCH_A;
               else if (!stall)
                  state <= EXEC_S;
            end
            EXEC_S: begin
               if (isBranch) begin
                  // An EI branch checks for interrupts with the new enable.
                  if (Instr[11])
                     IntEnabled <= 1'b1;
                  state <= ((IntEnabled | Instr[11]) & IntReq) ? INT_SAVE : FETCH_A;
               end else begin
                  state <= EXEC_W;
               end
            end
            EXEC_W: begin
               if (timeout)
                  state <= FETCH_A;
               else if (!stall)
                  state <= (IntEnabled & IntReq) ? INT_SAVE : FETCH_A;
            end
            INT_SAVE: state <= INT_JUMP;
            INT_JUMP: begin
               IntEnabled <= 1'b0;
               state      <= FETCH_A;
            end
            default: state <= FETCH_A;
         endcase
`ifdef MICROCODE_WAIT_EN
         // Only a stall keeps the state; any other cycle changes it.
         if (stall)
            waitCnt <= waitCnt + CW'(1);
         else
            waitCnt <= '0;
`endif
      end
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] Instr = 16'h0000;
   logic [4:0]  Flags = 5'h00;
   logic        MemReady = 1'b1;
   logic        IntReq = 1'b0;
   logic [2:0]  Step;
   logic        PCToA, PCW, PCWriteFromD, PCToD;
   logic        DToInstr, ALUToD, shiftInstrToD;
   logic [3:0]  rsel0RegFile, rsel1RegFile, wselRegFile;
   logic        wRegFile, rsel0ToA, rsel1ToD, wFlags, wOut;
   logic        IntEnabled, IntAck, BusErr;

   microcode_sequencer dut (
      .CLK(CLK), .RST(RST), .Instr(Instr), .Flags(Flags),
      .MemReady(MemReady), .IntReq(IntReq), .Step(Step),
      .PCToA(PCToA), .PCW(PCW), .PCWriteFromD(PCWriteFromD), .PCToD(PCToD),
      .DToInstr(DToInstr), .ALUToD(ALUToD), .shiftInstrToD(shiftInstrToD),
      .rsel0RegFile(rsel0RegFile), .rsel1RegFile(rsel1RegFile),
      .wselRegFile(wselRegFile), .wRegFile(wRegFile),
      .rsel0ToA(rsel0ToA), .rsel1ToD(rsel1ToD),
      .wFlags(wFlags), .wOut(wOut),
      .IntEnabled(IntEnabled), .IntAck(IntAck), .BusErr(BusErr)
   );

   always #5 CLK = ~CLK;

   localparam logic [14:0] S_PA  = 15'h4000;
   localparam logic [14:0] S_PW  = 15'h2000;
   localparam logic [14:0] S_PWD = 15'h1000;
   localparam logic [14:0] S_PD  = 15'h0800;
   localparam logic [14:0] S_DI  = 15'h0400;
   localparam logic [14:0] S_AD  = 15'h0200;
   localparam logic [14:0] S_SH  = 15'h0100;
   localparam logic [14:0] S_R0A = 15'h0080;
   localparam logic [14:0] S_R1D = 15'h0040;
   localparam logic [14:0] S_WR  = 15'h0020;
   localparam logic [14:0] S_WF  = 15'h0010;
   localparam logic [14:0] S_WO  = 15'h0008;
   localparam logic [14:0] S_IA  = 15'h0004;
   localparam logic [14:0] S_BE  = 15'h0002;
   localparam logic [14:0] S_IE  = 15'h0001;
   localparam logic [14:0] S_NO  = 15'h0000;

   logic [29:0] obs;
   assign obs = {Step, rsel0RegFile, rsel1RegFile, wselRegFile,
                 PCToA, PCW, PCWriteFromD, PCToD, DToInstr, ALUToD, shiftInstrToD,
                 rsel0ToA, rsel1ToD, wRegFile, wFlags, wOut, IntAck, BusErr, IntEnabled};

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] instr;
      logic [4:0]  flags;
      logic        intReq;
      logic [2:0]  step;
      logic [11:0] sel;
      logic [14:0] stb;
   } vecT;

   vecT vecs[$];

   task automatic add(input logic [15:0] i, input logic [4:0] f, input logic r,
                      input logic [2:0] st, input logic [11:0] sel, input logic [14:0] stb);
      vecT v;
      v.instr = i; v.flags = f; v.intReq = r; v.step = st; v.sel = sel; v.stb = stb;
      vecs.push_back(v);
   endtask

   task automatic addF(input logic [15:0] i, input logic [4:0] f, input logic [14:0] ie);
      add(i, f, 1'b0, 3'd0, 12'h000, S_PA | ie);
      add(i, f, 1'b0, 3'd1, 12'h000, S_PA | S_PW | S_DI | ie);
   endtask

   task automatic check(input string nm, input logic [2:0] st, input logic [11:0] sel,
                        input logic [14:0] stb);
      logic [29:0] expv;
      expv = {st, sel, stb};
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got step=%0d sel=%03h stb=%04h, expected step=%0d sel=%03h stb=%04h",
                  nm, obs[29:27], obs[26:15], obs[14:0], st, sel, stb);
      end
   endtask

   task automatic cyc(input logic [15:0] i, input logic [4:0] f, input logic mr, input logic r,
                      input logic [2:0] st, input logic [11:0] sel, input logic [14:0] stb,
                      input string nm);
      Instr = i; Flags = f; MemReady = mr; IntReq = r;
      @(negedge CLK);
      check(nm, st, sel, stb);
      @(posedge CLK);
      #1;
   endtask

   task automatic resetPulse();
      RST = 1'b1;
      @(negedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      // LDVAL, LDMEM, STR, MOV
      addF(16'h0123, 5'h00, S_NO);
      add(16'h0123, 5'h00, 1'b0, 3'd2, 12'h003, S_SH);
      add(16'h0123, 5'h00, 1'b0, 3'd3, 12'h003, S_SH | S_WR);
      addF(16'h8034, 5'h00, S_NO);
      add(16'h8034, 5'h00, 1'b0, 3'd2, 12'h403, S_R0A);
      add(16'h8034, 5'h00, 1'b0, 3'd3, 12'h403, S_R0A | S_WR);
      addF(16'h8125, 5'h00, S_NO);
      add(16'h8125, 5'h00, 1'b0, 3'd2, 12'h520, S_R0A | S_R1D);
      add(16'h8125, 5'h00, 1'b0, 3'd3, 12'h520, S_R0A | S_R1D | S_WO);
      addF(16'h8367, 5'h00, S_NO);
      add(16'h8367, 5'h00, 1'b0, 3'd2, 12'h076, S_R1D);
      add(16'h8367, 5'h00, 1'b0, 3'd3, 12'h076, S_R1D | S_WR);
      // ALU arithmetic and compare (IntReq at boundary ignored while disabled)
      addF(16'hC0AB, 5'h1F, S_NO);
      add(16'hC0AB, 5'h1F, 1'b0, 3'd2, 12'hAB0, S_AD);
      add(16'hC0AB, 5'h1F, 1'b0, 3'd3, 12'hAB0, S_AD | S_WR | S_WF);
      addF(16'hE0AB, 5'h00, S_NO);
      add(16'hE0AB, 5'h00, 1'b0, 3'd2, 12'hAB0, S_NO);
      add(16'hE0AB, 5'h00, 1'b1, 3'd3, 12'hAB0, S_WF);
      // branches: taken / not taken / inverted / unconditional
      addF(16'h9017, 5'h01, S_NO);
      add(16'h9017, 5'h01, 1'b0, 3'd2, 12'h070, S_R1D | S_PW | S_PWD);
      addF(16'h9017, 5'h00, S_NO);
      add(16'h9017, 5'h00, 1'b0, 3'd2, 12'h070, S_R1D);
      addF(16'h9417, 5'h00, S_NO);
      add(16'h9417, 5'h00, 1'b0, 3'd2, 12'h070, S_R1D | S_PW | S_PWD);
      addF(16'h9417, 5'h01, S_NO);
      add(16'h9417, 5'h01, 1'b0, 3'd2, 12'h070, S_R1D);
      addF(16'h9207, 5'h00, S_NO);
      add(16'h9207, 5'h00, 1'b0, 3'd2, 12'h070, S_R1D | S_PW | S_PWD);
      // EI branch with IntReq at its own boundary
      addF(16'h8800, 5'h00, S_NO);
      add(16'h8800, 5'h00, 1'b1, 3'd2, 12'h000, S_R1D);
      add(16'h8800, 5'h00, 1'b0, 3'd4, 12'h00E, S_PD | S_WR | S_IA | S_IE);
      add(16'h8800, 5'h00, 1'b0, 3'd5, 12'h0F0, S_R1D | S_PW | S_PWD | S_IE);
      // interrupts disabled again: IntReq at boundary ignored
      add(16'h0555, 5'h00, 1'b1, 3'd0, 12'h000, S_PA);
      add(16'h0555, 5'h00, 1'b0, 3'd1, 12'h000, S_PA | S_PW | S_DI);
      add(16'h0555, 5'h00, 1'b0, 3'd2, 12'h005, S_SH);
      add(16'h0555, 5'h00, 1'b1, 3'd3, 12'h005, S_SH | S_WR);
      // EI without request, then interrupt taken at an LDVAL boundary only
      addF(16'h8800, 5'h00, S_NO);
      add(16'h8800, 5'h00, 1'b0, 3'd2, 12'h000, S_R1D);
      add(16'h0A5C, 5'h00, 1'b1, 3'd0, 12'h000, S_PA | S_IE);
      add(16'h0A5C, 5'h00, 1'b0, 3'd1, 12'h000, S_PA | S_PW | S_DI | S_IE);
      add(16'h0A5C, 5'h00, 1'b0, 3'd2, 12'h00C, S_SH | S_IE);
      add(16'h0A5C, 5'h00, 1'b1, 3'd3, 12'h00C, S_SH | S_WR | S_IE);
      add(16'h0A5C, 5'h00, 1'b0, 3'd4, 12'h00E, S_PD | S_WR | S_IA | S_IE);
      add(16'h0A5C, 5'h00, 1'b0, 3'd5, 12'h0F0, S_R1D | S_PW | S_PWD | S_IE);
      add(16'h0001, 5'h00, 1'b0, 3'd0, 12'h000, S_PA);

      // reset state, with busy-looking inputs
      RST = 1'b1;
      @(posedge CLK); #1;
      Instr = 16'h8125; IntReq = 1'b1; MemReady = 1'b1;
      @(negedge CLK);
      check("rst_hold", 3'd0, 12'h000, S_PA);
      @(posedge CLK); #1;
      RST = 1'b0;

      for (int k = 0; k < vecs.size(); k++)
         cyc(vecs[k].instr, vecs[k].flags, 1'b1, vecs[k].intReq,
             vecs[k].step, vecs[k].sel, vecs[k].stb, $sformatf("vec%0d", k));

`ifdef MICROCODE_WAIT_EN
      // STR with three stalled EXEC_W cycles
      resetPulse();
      cyc(16'h8125, 5'h00, 1'b1, 1'b0, 3'd0, 12'h000, S_PA, "str_fa");
      cyc(16'h8125, 5'h00, 1'b1, 1'b0, 3'd1, 12'h000, S_PA | S_PW | S_DI, "str_fd");
      cyc(16'h8125, 5'h00, 1'b0, 1'b0, 3'd2, 12'h520, S_R0A | S_R1D, "str_es");
      for (int k = 0; k < 3; k++)
         cyc(16'h8125, 5'h00, 1'b0, 1'b0, 3'd3, 12'h520, S_R0A | S_R1D, $sformatf("str_wait%0d", k));
      cyc(16'h8125, 5'h00, 1'b1, 1'b0, 3'd3, 12'h520, S_R0A | S_R1D | S_WO, "str_wout");
      cyc(16'h8125, 5'h00, 1'b0, 1'b0, 3'd0, 12'h000, S_PA, "str_done");
      // fetch timeout after 16 stalled cycles
      for (int k = 0; k < 16; k++)
         cyc(16'h8125, 5'h00, 1'b0, 1'b0, 3'd1, 12'h000, S_PA, $sformatf("fd_stall%0d", k));
      cyc(16'h8125, 5'h00, 1'b1, 1'b0, 3'd1, 12'h000, S_PA | S_BE, "fd_buserr");
      cyc(16'h0123, 5'h00, 1'b0, 1'b0, 3'd0, 12'h000, S_PA, "after_buserr");
      // counter restarted: 15 stalls then completion, no error
      for (int k = 0; k < 15; k++)
         cyc(16'h0123, 5'h00, 1'b0, 1'b0, 3'd1, 12'h000, S_PA, $sformatf("fd_rstall%0d", k));
      cyc(16'h0123, 5'h00, 1'b1, 1'b0, 3'd1, 12'h000, S_PA | S_PW | S_DI, "fd_recover");
      cyc(16'h0123, 5'h00, 1'b0, 1'b0, 3'd2, 12'h003, S_SH, "ldval_es");
      cyc(16'h0123, 5'h00, 1'b0, 1'b0, 3'd3, 12'h003, S_SH | S_WR, "ldval_ew_nowait");
      cyc(16'h0123, 5'h00, 1'b0, 1'b0, 3'd0, 12'h000, S_PA, "ldval_done");
`else
      // MemReady ignored: LDMEM with MemReady low runs at zero-wait length
      resetPulse();
      cyc(16'h8034, 5'h00, 1'b0, 1'b0, 3'd0, 12'h000, S_PA, "nw_fa");
      cyc(16'h8034, 5'h00, 1'b0, 1'b0, 3'd1, 12'h000, S_PA | S_PW | S_DI, "nw_fd");
      cyc(16'h8034, 5'h00, 1'b0, 1'b0, 3'd2, 12'h403, S_R0A, "nw_es");
      cyc(16'h8034, 5'h00, 1'b0, 1'b0, 3'd3, 12'h403, S_R0A | S_WR, "nw_ew");
      cyc(16'h8034, 5'h00, 1'b0, 1'b0, 3'd0, 12'h000, S_PA, "nw_done");
`endif

      // reset asserted during LDMEM EXEC_W
      resetPulse();
      cyc(16'h8034, 5'h00, 1'b1, 1'b0, 3'd0, 12'h000, S_PA, "rm_fa");
      cyc(16'h8034, 5'h00, 1'b1, 1'b0, 3'd1, 12'h000, S_PA | S_PW | S_DI, "rm_fd");
      cyc(16'h8034, 5'h00, 1'b0, 1'b0, 3'd2, 12'h403, S_R0A, "rm_es");
      @(negedge CLK);
`ifdef MICROCODE_WAIT_EN
      check("rm_ew", 3'd3, 12'h403, S_R0A);
`else
      check("rm_ew", 3'd3, 12'h403, S_R0A | S_WR);
`endif
      RST = 1'b1;
      #1;
      check("rst_async", 3'd0, 12'h000, S_PA);
      @(posedge CLK); #1;
      MemReady = 1'b1;
      @(negedge CLK);
      check("rst_held", 3'd0, 12'h000, S_PA);
      @(posedge CLK); #1;
      RST = 1'b0;
      cyc(16'h8034, 5'h00, 1'b1, 1'b0, 3'd0, 12'h000, S_PA, "rst_release");
      cyc(16'h8034, 5'h00, 1'b1, 1'b0, 3'd1, 12'h000, S_PA | S_PW | S_DI, "rst_refetch");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
